// File: rtl/jtopl_wrbuf.sv
// jtopl_wrbuf - host-side write buffer and pacer for the jtopl family.
//
// Host writes are accepted with no wait states and stored in a FIFO. A
// pacer replays them into the synth core's write port one at a time. After
// each write it waits out the chip's recovery time, counted in cen ticks:
// ADDR_WAIT after an address-register write (addr[0]==0) and DATA_WAIT
// after a data-register write (addr[0]==1).
//
// Parameters:
//   AW        host/core address width (1 = OPL2, 2 = OPL3 bank in addr[1])
//   DEPTH     FIFO entries, power of two, >= 2
//   ADDR_WAIT cen ticks of recovery after an address write
//   DATA_WAIT cen ticks of recovery after a data write
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cen                  clock enable shared with the core (pacing time base)
//   host_din/addr/wr     host write port; host_wr is a one-cycle strobe
//   full, empty, level   registered FIFO status
//   busy                 FIFO non-empty or pacer not idle
//   core_din/addr        registered data/address to the core
//   core_cs_n/wr_n       registered active-low strobes to the core
//   ovf, ovf_clr         sticky overflow flag and its clear
//
// Optional feature: define JTOPL_WRBUF_OVF_EN to build the sticky overflow
// register. Without it, ovf is tied low and ovf_clr is ignored.
//
// Handshake: there is no back-pressure on the host. A host_wr is accepted
// only when full was low in that same cycle. full is sampled before any
// same-cycle pop, so a write that arrives while full is always dropped.

module jtopl_wrbuf #(
  parameter int AW        = 1,
  parameter int DEPTH     = 16,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic [7:0]             host_din,
  input  logic [AW-1:0]          host_addr,
  input  logic                   host_wr,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic [7:0]             core_din,
  output logic [AW-1:0]          core_addr,
  output logic                   core_cs_n,
  output logic                   core_wr_n,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int EW   = AW + 8;
  localparam int MAXW = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW   = (MAXW < 1) ? 1 : $clog2(MAXW + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push, pop;
  logic [EW-1:0] head;

  state_t        state_q;

  assign push = host_wr & ~full_q;
  // The pacer takes the head only from IDLE, so a pop never races a strobe.
  assign pop  = (state_q == ST_IDLE) & ~empty_q;
  assign head = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {host_addr, host_din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pacer
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q;
  logic [7:0]    din_q;
  logic [AW-1:0] addr_q;
  logic          cs_n_q;
  logic          wr_n_q;
  logic [CW-1:0] sel_wait;

  // Recovery time depends on which register the latched entry targets.
  assign sel_wait = addr_q[0] ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      addr_q  <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Popping does not wait for cen; only the strobe release does.
          if (!empty_q) begin
            {addr_q, din_q} <= head;
            cs_n_q          <= 1'b0;
            wr_n_q          <= 1'b0;
            state_q         <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          // The core samples the write on a cen edge, so hold the strobes
          // low through the first one.
          if (cen) begin
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            cnt_q   <= sel_wait;
            state_q <= (sel_wait == '0) ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cen) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
`ifdef JTOPL_WRBUF_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (host_wr && full_q) begin
      ovf_q <= 1'b1;  // a drop wins over a simultaneous clear
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign busy      = (state_q != ST_IDLE) | ~empty_q;
  assign core_din  = din_q;
  assign core_addr = addr_q;
  assign core_cs_n = cs_n_q;
  assign core_wr_n = wr_n_q;

endmodule

// File: tb/tb_jtopl_wrbuf.sv
// Bench for jtopl_wrbuf (AW=2, DEPTH=4, default recovery times).
// Directed scenarios run first, then a randomized run checked every cycle
// against a timeline model. The model derives each accepted write's strobe
// cycle from the pacing rules: strobe = max(visible, pacer free) + 1, and
// the pacer is free again W+1 cycles after the strobe.

module tb_jtopl_wrbuf;

  localparam int AW        = 2;
  localparam int DEPTH     = 4;
  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;
  localparam int LW        = $clog2(DEPTH) + 1;
`ifdef JTOPL_WRBUF_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b1;
  logic [7:0]    host_din = 8'h00;
  logic [AW-1:0] host_addr = '0;
  logic          host_wr = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          full, empty, busy, core_cs_n, core_wr_n, ovf;
  logic [LW-1:0] level;
  logic [7:0]    core_din;
  logic [AW-1:0] core_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit slow_cen = 1'b0;

  always #5 clk = ~clk;

  // cen for cycle c is driven just after the posedge that starts cycle c.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      cen = slow_cen ? (cyc % 4 == 0) : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  jtopl_wrbuf #(
    .AW(AW), .DEPTH(DEPTH), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .host_din(host_din), .host_addr(host_addr), .host_wr(host_wr),
    .full(full), .empty(empty), .level(level), .busy(busy),
    .core_din(core_din), .core_addr(core_addr),
    .core_cs_n(core_cs_n), .core_wr_n(core_wr_n),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // ---------------------------------------------------------------- strobe monitor
  int            mon_cyc[$];
  int            mon_len[$];
  logic [7:0]    mon_din[$];
  logic [AW-1:0] mon_addr[$];
  bit            prev_low = 1'b0;

  always @(negedge clk) begin
    if (!core_cs_n && !core_wr_n) begin
      if (!prev_low) begin
        mon_cyc.push_back(cyc);
        mon_len.push_back(1);
        mon_din.push_back(core_din);
        mon_addr.push_back(core_addr);
      end else begin
        mon_len[mon_len.size()-1] = mon_len[mon_len.size()-1] + 1;
      end
    end
    prev_low = !core_cs_n && !core_wr_n;
  end

  task automatic mon_clear();
    mon_cyc.delete();
    mon_len.delete();
    mon_din.delete();
    mon_addr.delete();
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic drive_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim && busy; k++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, lim);
    end
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({core_cs_n, core_wr_n, full, empty, busy, ovf} !== 6'b110100) begin
      n_fail++;
      $display("FAIL rst_flags: got %b want 110100",
               {core_cs_n, core_wr_n, full, empty, busy, ovf});
    end
    n_checks++;
    if ({level, core_addr, core_din} !== '0) begin
      n_fail++;
      $display("FAIL rst_values: level=%0d addr=%0d din=%02h, want all 0",
               level, core_addr, core_din);
    end
    drive_cycle();
    rst_n = 1'b1;
    repeat (2) drive_cycle();
  endtask

  task automatic test_spacing();
    int n, fall;
    mon_clear();
    drive_cycle();
    n = cyc;
    host_wr = 1'b1; host_addr = 2'b00; host_din = 8'h20;
    drive_cycle();
    host_addr = 2'b01; host_din = 8'h01;
    drive_cycle();
    host_wr = 1'b0;
    fall = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin fall = cyc; break; end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (mon_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL spacing_count: got %0d strobes want 2", mon_cyc.size());
    end else begin
      n_checks++;
      if ({mon_cyc[0], mon_len[0]} !== {n + 2, 32'd1}) begin
        n_fail++;
        $display("FAIL spacing_first: at %0d len %0d, want at %0d len 1",
                 mon_cyc[0], mon_len[0], n + 2);
      end
      n_checks++;
      if ({mon_addr[0], mon_din[0], mon_addr[1], mon_din[1]} !== {2'b00, 8'h20, 2'b01, 8'h01}) begin
        n_fail++;
        $display("FAIL spacing_data: got %0d/%02h %0d/%02h want 0/20 1/01",
                 mon_addr[0], mon_din[0], mon_addr[1], mon_din[1]);
      end
      n_checks++;
      if (mon_cyc[1] - mon_cyc[0] != ADDR_WAIT + 2) begin
        n_fail++;
        $display("FAIL spacing_gap: got %0d want %0d", mon_cyc[1] - mon_cyc[0], ADDR_WAIT + 2);
      end
      n_checks++;
      if (fall != mon_cyc[1] + DATA_WAIT + 1) begin
        n_fail++;
        $display("FAIL spacing_busy: busy fell at %0d want %0d", fall, mon_cyc[1] + DATA_WAIT + 1);
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    mon_clear();
    drive_cycle();
    n = cyc;
    for (int i = 0; i < 6; i++) begin
      host_wr = 1'b1; host_addr = 2'b00; host_din = 8'hA0 + 8'(i);
      if (i == 5) begin
        @(negedge clk);
        n_checks++;
        if ({full, empty, level} !== {1'b1, 1'b0, LW'(DEPTH)}) begin
          n_fail++;
          $display("FAIL ovf_full: full=%b empty=%b level=%0d want 1 0 %0d", full, empty, level, DEPTH);
        end
      end
      drive_cycle();
    end
    // still full: write plus clear in the same cycle
    host_wr = 1'b1; host_din = 8'hEE; ovf_clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ovf !== OVF_EN) begin
      n_fail++;
      $display("FAIL ovf_set: got %b want %b", ovf, OVF_EN);
    end
    drive_cycle();
    host_wr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovf !== OVF_EN) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b want %b", ovf, OVF_EN);
    end
    drive_cycle();
    ovf_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want 0", ovf);
    end
    wait_idle(400);
    n_checks++;
    if (mon_cyc.size() != 5) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d strobes want 5", mon_cyc.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (mon_din[i] !== 8'hA0 + 8'(i) || mon_cyc[i] != n + 2 + i * (ADDR_WAIT + 2)) begin
          n_fail++;
          $display("FAIL ovf_order[%0d]: din %02h at %0d want %02h at %0d",
                   i, mon_din[i], mon_cyc[i], 8'hA0 + 8'(i), n + 2 + i * (ADDR_WAIT + 2));
        end
      end
    end
  endtask

  task automatic test_slow_cen();
    int n, s1, c1, s2, c2, fall;
    mon_clear();
    slow_cen = 1'b1;
    drive_cycle();
    n = cyc;
    host_wr = 1'b1; host_addr = 2'b00; host_din = 8'h55;
    drive_cycle();
    host_addr = 2'b10; host_din = 8'h66;
    drive_cycle();
    host_wr = 1'b0;
    fall = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) begin fall = cyc; break; end
    end
    repeat (2) @(negedge clk);
    slow_cen = 1'b0;
    s1 = n + 2;
    c1 = s1 + (4 - s1 % 4) % 4;
    s2 = c1 + 4 * ADDR_WAIT + 2;
    c2 = s2 + (4 - s2 % 4) % 4;
    n_checks++;
    if (mon_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL slow_count: got %0d strobes want 2", mon_cyc.size());
    end else begin
      n_checks++;
      if (mon_cyc[0] != s1 || mon_len[0] != c1 - s1 + 1) begin
        n_fail++;
        $display("FAIL slow_first: at %0d len %0d want at %0d len %0d", mon_cyc[0], mon_len[0], s1, c1 - s1 + 1);
      end
      n_checks++;
      if (mon_cyc[1] != s2 || mon_len[1] != c2 - s2 + 1) begin
        n_fail++;
        $display("FAIL slow_second: at %0d len %0d want at %0d len %0d", mon_cyc[1], mon_len[1], s2, c2 - s2 + 1);
      end
      n_checks++;
      if ({mon_addr[0], mon_din[0], mon_addr[1], mon_din[1]} !== {2'b00, 8'h55, 2'b10, 8'h66}) begin
        n_fail++;
        $display("FAIL slow_data: got %0d/%02h %0d/%02h want 0/55 2/66",
                 mon_addr[0], mon_din[0], mon_addr[1], mon_din[1]);
      end
    end
    n_checks++;
    if (fall != c2 + 4 * ADDR_WAIT + 1) begin
      n_fail++;
      $display("FAIL slow_busy: busy fell at %0d want %0d", fall, c2 + 4 * ADDR_WAIT + 1);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    drive_cycle();
    host_wr = 1'b1; host_addr = 2'b01; host_din = 8'h11;
    drive_cycle();
    host_wr = 1'b0;
    repeat (4) drive_cycle();
    for (int i = 0; i < 3; i++) begin
      host_wr = 1'b1; host_addr = 2'b11; host_din = 8'h31 + 8'(i);
      drive_cycle();
    end
    host_wr = 1'b0;
    mon_clear();
    #1;
    n_checks++;
    if ({level, busy, core_din} !== {LW'(3), 1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL rmid_pre: level=%0d busy=%b din=%02h want 3 1 11", level, busy, core_din);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({core_cs_n, core_wr_n, full, empty, busy, ovf, level, core_addr, core_din} !==
        {6'b110100, LW'(0), 2'b00, 8'h00}) begin
      n_fail++;
      $display("FAIL rmid_async: flags=%b level=%0d addr=%0d din=%02h want 110100 0 0 00",
               {core_cs_n, core_wr_n, full, empty, busy, ovf}, level, core_addr, core_din);
    end
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (!(empty && level == '0 && core_cs_n && core_wr_n)) bad = 1'b1;
    end
    n_checks++;
    if (bad || mon_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_after: bad=%b strobes=%0d want 0 0", bad, mon_cyc.size());
    end
  endtask

  task automatic test_random();
    int            e_p[$], e_s[$], e_w[$];
    logic [7:0]    e_d[$];
    logic [AW-1:0] e_a[$];
    int            idle_at, c, lvl, s, w;
    bit            stb, act, wr, clr, acc;
    logic          ovf_exp;
    logic [7:0]    x_din, d;
    logic [AW-1:0] x_addr, a;
    idle_at = 0;
    ovf_exp = 1'b0;
    x_din   = 8'h00;
    x_addr  = '0;
    drive_cycle();
    for (int k = 0; k < 1500; k++) begin
      c = cyc; lvl = 0; stb = 1'b0; act = 1'b0;
      for (int j = 0; j < e_p.size(); j++) begin
        if (e_p[j] < c) lvl++;
        if (e_s[j] <= c) begin lvl--; x_din = e_d[j]; x_addr = e_a[j]; end
        if (e_s[j] == c) stb = 1'b1;
        if (e_s[j] <= c && c <= e_s[j] + e_w[j]) act = 1'b1;
      end
      wr  = (k < 900) && ($urandom_range(0, 5) == 0);
      clr = (k < 900) && ($urandom_range(0, 7) == 0);
      a   = AW'($urandom_range(0, 3));
      d   = 8'($urandom_range(0, 255));
      host_wr = wr; host_addr = a; host_din = d; ovf_clr = clr;
      acc = wr && (lvl < DEPTH);
      if (acc) begin
        s = ((c + 1 > idle_at) ? c + 1 : idle_at) + 1;
        w = a[0] ? DATA_WAIT : ADDR_WAIT;
        idle_at = s + 1 + w;
        e_p.push_back(c); e_s.push_back(s); e_w.push_back(w);
        e_d.push_back(d); e_a.push_back(a);
      end
      @(negedge clk);
      n_checks++;
      if ({core_cs_n, core_wr_n, full, empty, busy, ovf} !==
          {~stb, ~stb, lvl == DEPTH, lvl == 0, (lvl > 0) || act, ovf_exp}) begin
        n_fail++;
        $display("FAIL rnd_flags @%0d: got %b want %b", c,
                 {core_cs_n, core_wr_n, full, empty, busy, ovf},
                 {~stb, ~stb, lvl == DEPTH, lvl == 0, (lvl > 0) || act, ovf_exp});
      end
      n_checks++;
      if (level !== LW'(lvl)) begin
        n_fail++;
        $display("FAIL rnd_level @%0d: got %0d want %0d", c, level, lvl);
      end
      n_checks++;
      if ({core_addr, core_din} !== {x_addr, x_din}) begin
        n_fail++;
        $display("FAIL rnd_data @%0d: got %0d/%02h want %0d/%02h", c, core_addr, core_din, x_addr, x_din);
      end
      if (OVF_EN) begin
        if (wr && !acc) ovf_exp = 1'b1;
        else if (clr) ovf_exp = 1'b0;
      end
      drive_cycle();
    end
    host_wr = 1'b0;
    ovf_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_spacing();
    test_overflow();
    test_slow_cen();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
